muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL take no parameters; data width is fixed at 32 bits, matching the register file data width.
REQ-002 The block SHALL run on one clock; reset is synchronous and active-high. Ports are named clk and reset.
REQ-003 clk  input  1  rising-edge clock, shared with the register file.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  decoder flags an RV32M instruction this cycle.
REQ-006 Funct3  input  3  opcode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Operand1  input  32  rs1 value (register file ReadData1).
REQ-008 Operand2  input  32  rs2 value (register file ReadData2).
REQ-009 DestAddr  input  5  rd index.
REQ-010 Stall  output  1  combinational; holds the PC and the fetch stage while high.
REQ-011 Busy  output  1  registered; high in states CALC and DONE.
REQ-012 Done  output  1  registered; one-cycle completion pulse.
REQ-013 RegWrite  output  1  register file write enable.
REQ-014 WriteRegAddr  output  5  register file write address.
REQ-015 WriteData  output  32  result to be written to the register file.

Function
REQ-016 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-017 Transition IDLE->CALC: Start=1 in IDLE. At that edge the block SHALL latch Funct3, Operand1, Operand2 and DestAddr, and clear the iteration counter to 0.
REQ-018 Start SHALL be ignored in CALC and DONE. Changes on Operand1, Operand2, Funct3 and DestAddr after acceptance SHALL NOT affect the result.
REQ-019 CALC SHALL perform exactly one radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-020 Transition CALC->DONE: after the 32nd iteration (counter = 31 at the edge). Transition DONE->IDLE: unconditionally after one cycle.
REQ-021 Latency SHALL be fixed. With Start accepted in cycle 0, CALC occupies cycles 1-32, DONE is cycle 33, and IDLE is reached in cycle 34. No operand value or opcode shall cause an early exit.
REQ-022 Stall = (IDLE and Start) or CALC. Stall SHALL be low in DONE so the instruction retires in cycle 33.
REQ-023 In DONE, Done SHALL be 1, and RegWrite SHALL be 1 only if the latched DestAddr is non-zero.
REQ-024 In DONE, WriteRegAddr SHALL equal the latched DestAddr and WriteData SHALL hold the result. Outside DONE, Done, RegWrite, WriteRegAddr and WriteData SHALL be 0.
REQ-025 Signed operations SHALL use magnitudes internally and apply the sign correction in the DONE cycle. MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32] under signed×signed, signed×unsigned and unsigned×unsigned interpretation respectively.
REQ-026 The quotient SHALL truncate toward zero, and the remainder sign SHALL follow the dividend.
REQ-027 Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return Operand1. Latency is unchanged.
REQ-028 Signed overflow (0x80000000 DIV 0xFFFFFFFF): the result SHALL be 0x80000000, and REM SHALL be 0.
REQ-029 All arithmetic SHALL be modulo 2^32 (2^64 for the internal product). No exceptions or flags shall be raised.

Reset
REQ-030 While reset=1 at a clock edge, the state SHALL go to IDLE and the counter and all latched operands SHALL clear to 0.
REQ-031 Busy, Done, RegWrite, WriteRegAddr and WriteData SHALL be 0 in the cycle after the reset edge.
REQ-032 Reset mid-operation (CALC or DONE) SHALL abort the operation with no Done pulse and no register write.
REQ-033 Reset SHALL take priority over Start in the same cycle; Stall SHALL be 0 while reset is high.

Verification
REQ-034 MUL 7×6, rd=5, Start in cycle 0 -> Stall high cycles 0-32; cycle 33: Done=1, RegWrite=1, WriteRegAddr=5, WriteData=42.
REQ-035 MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
REQ-036 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100. All complete in cycle 33.
REQ-037 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. Operands change in cycle 5 and a second Start is pulsed in cycle 10 -> result unaffected, no second operation.
REQ-038 MUL with rd=0 -> Done=1 and RegWrite=0 in cycle 33.
REQ-039 Reset asserted in cycle 15 of a DIV -> IDLE in cycle 16, no Done pulse; a fresh Start in cycle 17 completes in cycle 50.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/response bundle between the RV32M decode stage and the iterative multiply/divide unit.
interface muldiv_if;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [4:0]  DestAddr;
  logic        Stall;
  logic        Busy;
  logic        Done;
  logic        RegWrite;
  logic [4:0]  WriteRegAddr;
  logic [31:0] WriteData;

  modport slave (
    input  Start, Funct3, Operand1, Operand2, DestAddr,
    output Stall, Busy, Done, RegWrite, WriteRegAddr, WriteData
  );

  modport master (
    output Start, Funct3, Operand1, Operand2, DestAddr,
    input  Stall, Busy, Done, RegWrite, WriteRegAddr, WriteData
  );
endinterface

// File: rtl/muldiv_unit.sv
// Fixed-latency radix-2 RV32M multiply/divide unit: 32 iterations on operand magnitudes,
// sign correction folded into the result written in the DONE cycle.
module muldiv_unit (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state;
  logic [4:0]  cnt;
  logic [2:0]  f3_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [4:0]  rd_q;
  logic [63:0] acc_q;   // mul: {hi, lo} partial product; div: {remainder, quotient}
  logic [31:0] b_q;     // multiplicand or divisor magnitude

  logic        busy_q;
  logic        done_q;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  function automatic logic op1_signed(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
  endfunction

  function automatic logic op2_signed(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
  endfunction

  // Magnitudes of the incoming operands, captured at acceptance
  logic        in_neg1, in_neg2;
  logic [31:0] in_mag1, in_mag2;

  always_comb begin
    in_neg1 = op1_signed(bus.Funct3) & bus.Operand1[31];
    in_neg2 = op2_signed(bus.Funct3) & bus.Operand2[31];
    in_mag1 = in_neg1 ? (~bus.Operand1 + 32'd1) : bus.Operand1;
    in_mag2 = in_neg2 ? (~bus.Operand2 + 32'd1) : bus.Operand2;
  end

  // One iteration step
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_nxt;
  logic [63:0] acc_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_nxt   = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[31:0] - b_q;
    div_nxt   = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                       : {div_shift[31:0], acc_q[30:0], 1'b0};
    acc_nxt   = f3_q[2] ? div_nxt : mul_nxt;
  end

  // Final result from the last iteration's value, with sign correction
  logic        neg1, neg2, div0;
  logic [63:0] prod;
  logic [31:0] quo, rem, quo_s, rem_s, result;

  always_comb begin
    neg1   = op1_signed(f3_q) & op1_q[31];
    neg2   = op2_signed(f3_q) & op2_q[31];
    div0   = (op2_q == 32'd0);
    prod   = (neg1 ^ neg2) ? (~acc_nxt + 64'd1) : acc_nxt;
    quo    = acc_nxt[31:0];
    rem    = acc_nxt[63:32];
    quo_s  = (neg1 ^ neg2) ? (~quo + 32'd1) : quo;
    rem_s  = neg1 ? (~rem + 32'd1) : rem;
    result = 32'd0;
    case (f3_q)
      3'b000:                 result = prod[31:0];
      3'b001, 3'b010, 3'b011: result = prod[63:32];
      3'b100:                 result = div0 ? 32'hFFFF_FFFF : quo_s;
      3'b101:                 result = div0 ? 32'hFFFF_FFFF : quo;
      3'b110:                 result = div0 ? op1_q : rem_s;
      3'b111:                 result = div0 ? op1_q : rem;
      default:                result = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      cnt     <= 5'd0;
      f3_q    <= 3'd0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      rd_q    <= 5'd0;
      acc_q   <= 64'd0;
      b_q     <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.Start) begin
            state  <= StCalc;
            cnt    <= 5'd0;
            f3_q   <= bus.Funct3;
            op1_q  <= bus.Operand1;
            op2_q  <= bus.Operand2;
            rd_q   <= bus.DestAddr;
            acc_q  <= {32'd0, bus.Funct3[2] ? in_mag1 : in_mag2};
            b_q    <= bus.Funct3[2] ? in_mag2 : in_mag1;
            busy_q <= 1'b1;
          end
        end
        StCalc: begin
          acc_q <= acc_nxt;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state   <= StDone;
            done_q  <= 1'b1;
            we_q    <= (rd_q != 5'd0);
            waddr_q <= rd_q;
            wdata_q <= result;
          end
        end
        StDone: begin
          state   <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
          waddr_q <= 5'd0;
          wdata_q <= 32'd0;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.Stall        = ~reset & (((state == StIdle) & bus.Start) | (state == StCalc));
  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;
  assign bus.RegWrite     = we_q;
  assign bus.WriteRegAddr = waddr_q;
  assign bus.WriteData    = wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: cycle-exact latency, results, rd=0, interference and reset abort.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic        o_stall0, o_stall33, o_busy33, o_busy34, o_done34;
  logic        o_done, o_we;
  logic [4:0]  o_addr;
  logic [31:0] o_data;
  int          stall_bad;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts in cycle 0 (caller is just past a posedge), leaves the bench at the start of cycle 35.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    bus.Start = 1'b1; bus.Funct3 = f; bus.Operand1 = a; bus.Operand2 = b; bus.DestAddr = rd;
    @(negedge clk);
    o_stall0 = bus.Stall;
    next_cycle();
    bus.Start = 1'b0;
    stall_bad = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (!bus.Stall || !bus.Busy || bus.Done || bus.RegWrite) stall_bad++;
      next_cycle();
    end
    @(negedge clk);
    o_done = bus.Done; o_we = bus.RegWrite; o_addr = bus.WriteRegAddr; o_data = bus.WriteData;
    o_stall33 = bus.Stall; o_busy33 = bus.Busy;
    next_cycle();
    @(negedge clk);
    o_busy34 = bus.Busy; o_done34 = bus.Done;
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.Start = 1'b1; bus.Funct3 = 3'b000;
    bus.Operand1 = 32'd3; bus.Operand2 = 32'd4; bus.DestAddr = 5'd1;
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.Stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.Stall);
    end
    next_cycle();
    reset = 1'b0; bus.Start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.Busy, bus.Done, bus.RegWrite, bus.Stall} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000",
                         {bus.Busy, bus.Done, bus.RegWrite, bus.Stall});
    end
    n_cmp++;
    if ({bus.WriteRegAddr, bus.WriteData} !== 37'd0) begin
      n_fail++; $display("FAIL reset_write: got %h/%h expected 0/0",
                         bus.WriteRegAddr, bus.WriteData);
    end
    next_cycle();
  endtask

  task automatic test_mul_timing();
    run_op(3'b000, 32'd7, 32'd6, 5'd5);
    n_cmp++;
    if (o_stall0 !== 1'b1) begin n_fail++; $display("FAIL mul_stall0: got %b expected 1", o_stall0); end
    n_cmp++;
    if (stall_bad !== 0) begin n_fail++; $display("FAIL mul_calc_window: got %0d bad cycles expected 0", stall_bad); end
    n_cmp++;
    if ({o_done, o_we, o_busy33, o_stall33} !== 4'b1110) begin
      n_fail++; $display("FAIL mul_done_flags: got %b expected 1110", {o_done, o_we, o_busy33, o_stall33});
    end
    n_cmp++;
    if (o_addr !== 5'd5) begin n_fail++; $display("FAIL mul_addr: got %0d expected 5", o_addr); end
    n_cmp++;
    if (o_data !== 32'd42) begin n_fail++; $display("FAIL mul_data: got %h expected 0000002a", o_data); end
    n_cmp++;
    if ({o_busy34, o_done34} !== 2'b00) begin
      n_fail++; $display("FAIL mul_idle34: got %b expected 00", {o_busy34, o_done34});
    end
  endtask

  task automatic test_mul_high();
    logic [2:0]  f  [5] = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b001};
    logic [31:0] a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000};
    logic [31:0] b  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'h8000_0000};
    logic [31:0] ex [5] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h4000_0000};
    for (int i = 0; i < 5; i++) begin
      run_op(f[i], a[i], b[i], 5'd7);
      n_cmp++;
      if (o_data !== ex[i] || o_done !== 1'b1) begin
        n_fail++; $display("FAIL mul_vec%0d: got %h done=%b expected %h done=1", i, o_data, o_done, ex[i]);
      end
    end
  endtask

  task automatic test_divide();
    logic [2:0]  f  [7] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100};
    logic [31:0] a  [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] b  [7] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0};
    logic [31:0] ex [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100,
                            32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      run_op(f[i], a[i], b[i], 5'd9);
      n_cmp++;
      if (o_data !== ex[i] || o_done !== 1'b1 || stall_bad !== 0) begin
        n_fail++; $display("FAIL div_vec%0d: got %h done=%b bad=%0d expected %h done=1 bad=0",
                           i, o_data, o_done, stall_bad, ex[i]);
      end
    end
  endtask

  task automatic test_overflow_interference();
    bus.Start = 1'b1; bus.Funct3 = 3'b100; bus.DestAddr = 5'd12;
    bus.Operand1 = 32'h8000_0000; bus.Operand2 = 32'hFFFF_FFFF;
    next_cycle();
    for (int c = 1; c <= 32; c++) begin
      if (c == 5) begin
        bus.Funct3 = 3'b000; bus.Operand1 = 32'd7; bus.Operand2 = 32'd3; bus.DestAddr = 5'd9;
      end
      bus.Start = (c == 10);
      next_cycle();
    end
    @(negedge clk);
    n_cmp++;
    if (bus.Done !== 1'b1 || bus.WriteData !== 32'h8000_0000 || bus.WriteRegAddr !== 5'd12) begin
      n_fail++; $display("FAIL div_ovf: got done=%b %h rd=%0d expected done=1 80000000 rd=12",
                         bus.Done, bus.WriteData, bus.WriteRegAddr);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({bus.Busy, bus.Done} !== 2'b00) begin
      n_fail++; $display("FAIL div_ovf_idle: got %b expected 00", {bus.Busy, bus.Done});
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({bus.Busy, bus.Stall} !== 2'b00) begin
      n_fail++; $display("FAIL no_second_op: got %b expected 00", {bus.Busy, bus.Stall});
    end
    next_cycle();
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    n_cmp++;
    if (o_data !== 32'd0 || o_done !== 1'b1) begin
      n_fail++; $display("FAIL rem_ovf: got %h done=%b expected 00000000 done=1", o_data, o_done);
    end
  endtask

  task automatic test_rd_zero();
    run_op(3'b000, 32'd3, 32'd4, 5'd0);
    n_cmp++;
    if ({o_done, o_we} !== 2'b10) begin
      n_fail++; $display("FAIL rd_zero: got done/we=%b expected 10", {o_done, o_we});
    end
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    bus.Start = 1'b1; bus.Funct3 = 3'b100; bus.DestAddr = 5'd3;
    bus.Operand1 = 32'hFFFF_FFF9; bus.Operand2 = 32'd2;
    next_cycle();
    bus.Start = 1'b0;
    for (int c = 1; c < 15; c++) next_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stall: got %b expected 0", bus.Stall); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.Busy, bus.Done, bus.RegWrite} !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset_idle: got %b expected 000", {bus.Busy, bus.Done, bus.RegWrite});
    end
    next_cycle();
    run_op(3'b101, 32'd100, 32'd7, 5'd4);
    if (stall_bad != 0) seen_done = 1;
    n_cmp++;
    if (o_data !== 32'd14 || o_done !== 1'b1 || o_addr !== 5'd4 || seen_done !== 0) begin
      n_fail++; $display("FAIL restart_after_reset: got %h done=%b rd=%0d early=%0d expected 0000000e done=1 rd=4 early=0",
                         o_data, o_done, o_addr, seen_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul_timing();
    test_mul_high();
    test_divide();
    test_overflow_interference();
    test_rd_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
